video_color_adjust_pipe: RTL and testbench
==========================================

// Module: video_color_adjust_pipe
// PURPOSE
//  Per-channel gain/offset colour and brightness adjust for the RGB888 HDMI video path, with frame-synchronous fade engine.
//  Sits between video source and HDMI encoder; replaces fixed +10-step brightness/colour adder with parametrised, saturating, pipelined datapath.
//  Coefficient updates take effect only at frame start, so no visible tearing.
// PARAMETERS
//  CW        8   bits per colour component (data width = 3*CW)
//  GW        9   unsigned gain width; FRAC fraction bits (unity = 1<<FRAC)
//  FRAC      7   gain fraction bits (GW=9,FRAC=7 -> gain 0.0..3.99)
//  OW        9   signed per-channel offset width (two's complement)
//  FADE_STEP 8   fade level change per frame (level range 0..256)
//  VS_POL    1   vs_in active level; frame start = vs_in edge into active level
// PORTS
//  clk         in   1      pixel clock
//  rst_n       in   1      asynchronous active-low reset
//  cfg_valid   in   1      new coefficient set offered
//  cfg_ready   out  1      coefficient set can be accepted
//  cfg_gain    in   3*GW   {R,G,B} unsigned gains
//  cfg_off     in   3*OW   {R,G,B} signed offsets
//  cfg_bypass  in   1      1: pass data unmodified (still delayed)
//  fade_cmd    in   2      00 none, 01 fade-in start, 10 fade-out start, 11 none
//  fade_busy   out  1      fade in progress
//  hs_in/vs_in/de_in in 1  input syncs / data enable
//  data_in     in   3*CW   {R,G,B} pixel
//  hs_out/vs_out/de_out out 1  syncs delayed by LAT
//  data_out    out  3*CW   adjusted pixel
// BEHAVIOUR
//  Reset: all outputs 0 except cfg_ready=1; active gains = 1<<FRAC, offsets 0, bypass 0, fade level 256, fade state IDLE.
//  Config FSM: CFG_IDLE -> (cfg_valid&&cfg_ready) latch into shadow, cfg_ready=0 -> CFG_PEND.
//   CFG_PEND -> at frame start: shadow copied to active set, cfg_ready=1 next cycle -> CFG_IDLE.
//   cfg_valid while PEND ignored (no overwrite). Accept and frame start same cycle: applied next frame.
//  Frame start (fs): single-cycle pulse, vs_in registered edge into VS_POL level.
//  Datapath, LAT = 4 cycles, fully pipelined, one pixel/clk:
//   S1 p = d*gain (CW+GW bits).  S2 q = (p + (1<<(FRAC-1))) >> FRAC; s = q + sext(off) signed.
//   S3 c = clamp(s, 0, 2^CW-1).  S4 o = (c*level + 128) >> 8, level in 0..256 (256 -> o=c exactly).
//  Bypass: o = d at same LAT. de_in=0: data_out = 0 for that pixel.
//  hs/vs/de delayed LAT registers; alignment with data exact, no bubbles.
//  Active coefficients, level and bypass sampled at S1 entry; change exactly at fs, never mid-line.
//  Fade FSM: IDLE/IN/OUT. fade_cmd 01 -> IN, level forced 0 at next fs then +FADE_STEP each fs, sat 256 -> IDLE.
//   fade_cmd 10 -> OUT, level -FADE_STEP each fs, sat 0 -> IDLE (level held 0: black).
//   New cmd during fade: direction reversed from current level, no jump. fade_busy=1 in IN/OUT.
//  Async reset mid-frame: pipeline flushed to 0, pending config discarded.
// TESTING
//  Gain 128 (1.0), off 0, level 256: data 0x123456 -> same after exactly 4 clk, syncs aligned.
//  Gain R=256 (2.0), off R=+100: R_in 200 -> 255 (clamp); off G=-50, G_in 30 -> 0.
//  Rounding: gain 192 (1.5), R_in 3 -> 5 ((576+64)>>7=5).
//  cfg accepted mid-frame -> old output until fs; new from first pixel after fs; cfg_ready 0 then 1.
//  fade_cmd=10, FADE_STEP=64: levels 192,128,64,0 over 4 frames, data 200 -> 150,100,50,0; fade_busy drops.
//  rst_n low mid-line -> outputs 0 async; release -> unity behaviour, cfg_ready=1.

Source files
------------

// File: rtl/video_color_adjust_pipe_if.sv
// Pixel, sync, coefficient-handshake and fade-control bundle for the colour adjust pipe.
interface video_color_adjust_pipe_if #(
  parameter int unsigned CW = 8,
  parameter int unsigned GW = 9,
  parameter int unsigned OW = 9
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [3*GW-1:0] cfg_gain;
  logic [3*OW-1:0] cfg_off;
  logic            cfg_bypass;
  logic [1:0]      fade_cmd;
  logic            fade_busy;
  logic            hs_in;
  logic            vs_in;
  logic            de_in;
  logic [3*CW-1:0] data_in;
  logic            hs_out;
  logic            vs_out;
  logic            de_out;
  logic [3*CW-1:0] data_out;

  modport master (
    output cfg_valid, cfg_gain, cfg_off, cfg_bypass, fade_cmd,
    output hs_in, vs_in, de_in, data_in,
    input  cfg_ready, fade_busy, hs_out, vs_out, de_out, data_out
  );

  modport slave (
    input  cfg_valid, cfg_gain, cfg_off, cfg_bypass, fade_cmd,
    input  hs_in, vs_in, de_in, data_in,
    output cfg_ready, fade_busy, hs_out, vs_out, de_out, data_out
  );
endinterface

// File: rtl/video_color_adjust_pipe.sv
// RGB gain/offset/brightness adjust, 4-stage saturating pipeline with
// frame-synchronous coefficient update and fade-in/out level engine.
module video_color_adjust_pipe #(
  parameter int unsigned CW        = 8,
  parameter int unsigned GW        = 9,
  parameter int unsigned FRAC      = 7,
  parameter int unsigned OW        = 9,
  parameter int unsigned FADE_STEP = 8,
  parameter bit          VS_POL    = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  video_color_adjust_pipe_if.slave bus
);
  localparam int unsigned PW = CW + GW;
  localparam int unsigned QW = PW + 1 - FRAC;
  localparam int unsigned SW = ((QW > OW) ? QW : OW) + 2;
  localparam int unsigned LW = 9;
  localparam int unsigned MW = CW + LW + 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(256);
  localparam logic [LW:0]   STEP    = (LW+1)'(FADE_STEP);

  typedef enum logic       {CFG_IDLE, CFG_PEND} cfg_st_t;
  typedef enum logic [1:0] {FADE_IDLE, FADE_IN, FADE_OUT} fade_st_t;

  cfg_st_t         r_cfg_st, w_cfg_nxt;
  fade_st_t        r_fade_st, w_fade_nxt;
  logic            r_vs_d, w_fs;
  logic            w_cfg_ready, w_accept, w_apply, w_fade_busy;
  logic [3*GW-1:0] r_sh_gain, r_gain;
  logic [3*OW-1:0] r_sh_off, r_off;
  logic            r_sh_byp, r_byp;
  logic [LW-1:0]   r_level, w_lvl_up, w_lvl_dn;
  logic            r_force0;

  logic [PW-1:0]          r1_p [3];
  logic [3*OW-1:0]        r1_off;
  logic signed [SW-1:0]   r2_s [3];
  logic [3*CW-1:0]        r3_c, r4_data;
  logic [3*CW-1:0]        r1_d, r2_d, r3_d;
  logic [LW-1:0]          r1_lvl, r2_lvl, r3_lvl;
  logic [2:0]             r_byp_sr;
  logic [3:0]             r_hs_sr, r_vs_sr, r_de_sr;
  logic [QW-1:0]          w_q [3];
  logic signed [SW-1:0]   w_s [3];
  logic [MW-1:0]          w_mix [3];
  logic [3*CW-1:0]        w_o;

  assign w_fs = (bus.vs_in == VS_POL) && (r_vs_d != VS_POL);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vs_d <= VS_POL;
    else        r_vs_d <= bus.vs_in;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cfg_st <= CFG_IDLE;
    else        r_cfg_st <= w_cfg_nxt;

  // An offer coinciding with frame start is latched but waits for the next frame.
  always_comb begin
    w_cfg_nxt = r_cfg_st;
    case (r_cfg_st)
      CFG_IDLE: if (bus.cfg_valid) w_cfg_nxt = CFG_PEND;
      CFG_PEND: if (w_fs)          w_cfg_nxt = CFG_IDLE;
      default:                     w_cfg_nxt = CFG_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_ready = (r_cfg_st == CFG_IDLE);
    w_accept    = w_cfg_ready && bus.cfg_valid;
    w_apply     = (r_cfg_st == CFG_PEND) && w_fs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_gain <= '0;
      r_sh_off  <= '0;
      r_sh_byp  <= 1'b0;
      r_gain    <= {3{GW'(1 << FRAC)}};
      r_off     <= '0;
      r_byp     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sh_gain <= bus.cfg_gain;
        r_sh_off  <= bus.cfg_off;
        r_sh_byp  <= bus.cfg_bypass;
      end
      if (w_apply) begin
        r_gain <= r_sh_gain;
        r_off  <= r_sh_off;
        r_byp  <= r_sh_byp;
      end
    end
  end

  always_comb begin
    w_lvl_up = (({1'b0, r_level} + STEP) >= (LW+1)'(256)) ? LVL_MAX
                                                         : LW'({1'b0, r_level} + STEP);
    w_lvl_dn = ({1'b0, r_level} <= STEP) ? '0 : LW'({1'b0, r_level} - STEP);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_fade_st <= FADE_IDLE;
    else        r_fade_st <= w_fade_nxt;

  always_comb begin
    w_fade_nxt = r_fade_st;
    case (r_fade_st)
      FADE_IDLE:
        if (bus.fade_cmd == 2'b01)      w_fade_nxt = FADE_IN;
        else if (bus.fade_cmd == 2'b10) w_fade_nxt = FADE_OUT;
      FADE_IN:
        if (bus.fade_cmd == 2'b10)                            w_fade_nxt = FADE_OUT;
        else if (w_fs && !r_force0 && (w_lvl_up == LVL_MAX))  w_fade_nxt = FADE_IDLE;
      FADE_OUT:
        if (bus.fade_cmd == 2'b01)              w_fade_nxt = FADE_IN;
        else if (w_fs && (w_lvl_dn == '0))      w_fade_nxt = FADE_IDLE;
      default: w_fade_nxt = FADE_IDLE;
    endcase
  end

  always_comb w_fade_busy = (r_fade_st != FADE_IDLE);

  // Only a fade-in started from idle jumps to black; a reversal ramps from the current level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= LVL_MAX;
      r_force0 <= 1'b0;
    end else begin
      if (w_fs) begin
        case (r_fade_st)
          FADE_IN:  r_level <= r_force0 ? '0 : w_lvl_up;
          FADE_OUT: r_level <= w_lvl_dn;
          default:  r_level <= r_level;
        endcase
      end
      if ((r_fade_st == FADE_IDLE) && (bus.fade_cmd == 2'b01))
        r_force0 <= 1'b1;
      else if ((r_fade_st != FADE_IDLE) && (w_fs || (w_fade_nxt != FADE_IN)))
        r_force0 <= 1'b0;
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      w_q[ch]   = QW'(({1'b0, r1_p[ch]} + (PW+1)'(1 << (FRAC-1))) >> FRAC);
      w_s[ch]   = $signed({{(SW-QW){1'b0}}, w_q[ch]})
                + $signed({{(SW-OW){r1_off[ch*OW+OW-1]}}, r1_off[ch*OW +: OW]});
      w_mix[ch] = MW'(r3_c[ch*CW +: CW]) * MW'(r3_lvl) + MW'(128);
      w_o[ch*CW +: CW] = CW'(w_mix[ch] >> 8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        r1_p[ch] <= '0;
        r2_s[ch] <= '0;
      end
      r1_off   <= '0;
      r3_c     <= '0;
      r4_data  <= '0;
      r1_d     <= '0;
      r2_d     <= '0;
      r3_d     <= '0;
      r1_lvl   <= '0;
      r2_lvl   <= '0;
      r3_lvl   <= '0;
      r_byp_sr <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
      r_de_sr  <= '0;
    end else begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        r1_p[ch] <= PW'(bus.data_in[ch*CW +: CW]) * PW'(r_gain[ch*GW +: GW]);
        r2_s[ch] <= w_s[ch];
        if (r2_s[ch][SW-1])           r3_c[ch*CW +: CW] <= '0;
        else if (|r2_s[ch][SW-2:CW])  r3_c[ch*CW +: CW] <= '1;
        else                          r3_c[ch*CW +: CW] <= r2_s[ch][CW-1:0];
      end
      r1_off   <= r_off;
      r1_lvl   <= r_level;
      r2_lvl   <= r1_lvl;
      r3_lvl   <= r2_lvl;
      r1_d     <= bus.data_in;
      r2_d     <= r1_d;
      r3_d     <= r2_d;
      r_byp_sr <= {r_byp_sr[1:0], r_byp};
      r_hs_sr  <= {r_hs_sr[2:0], bus.hs_in};
      r_vs_sr  <= {r_vs_sr[2:0], bus.vs_in};
      r_de_sr  <= {r_de_sr[2:0], bus.de_in};
      r4_data  <= !r_de_sr[2] ? '0 : (r_byp_sr[2] ? r3_d : w_o);
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.fade_busy = w_fade_busy;
  assign bus.hs_out    = r_hs_sr[3];
  assign bus.vs_out    = r_vs_sr[3];
  assign bus.de_out    = r_de_sr[3];
  assign bus.data_out  = r4_data;
endmodule

// File: tb/tb_video_color_adjust_pipe.sv
// Directed bench for video_color_adjust_pipe: latency, gain/offset/clamp,
// rounding, frame-synchronous config, bypass, fade ramps and async reset.
module tb_video_color_adjust_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0] fo_exp [4];
  logic [7:0] fi_exp [5];

  always #5 clk = ~clk;

  video_color_adjust_pipe_if #(.CW(8), .GW(9), .OW(9)) bus ();

  video_color_adjust_pipe #(
    .CW(8), .GW(9), .FRAC(7), .OW(9), .FADE_STEP(64), .VS_POL(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic pixel(input string tag, input logic [23:0] din, input logic de,
                       input logic [23:0] dexp);
    bus.data_in = din;
    bus.de_in   = de;
    bus.hs_in   = 1'b1;
    tick();
    bus.data_in = '0;
    bus.de_in   = 1'b0;
    bus.hs_in   = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, {6'b0, bus.de_out, bus.hs_out, bus.data_out}, 32'h0);
    tick();
    chk(tag, {6'b0, bus.de_out, bus.hs_out, bus.data_out}, {6'b0, de, 1'b1, dexp});
  endtask

  task automatic frame();
    bus.vs_in = 1'b1;
    tick();
    bus.vs_in = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [8:0] gr, gg, gb, orr, og, ob, input logic byp);
    bus.cfg_gain   = {gr, gg, gb};
    bus.cfg_off    = {orr, og, ob};
    bus.cfg_bypass = byp;
    bus.cfg_valid  = 1'b1;
    tick();
    bus.cfg_valid  = 1'b0;
  endtask

  task automatic fade(input logic [1:0] cmd);
    bus.fade_cmd = cmd;
    tick();
    bus.fade_cmd = 2'b00;
  endtask

  initial begin
    fo_exp = '{8'd150, 8'd100, 8'd50, 8'd0};
    fi_exp = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd200};
    bus.cfg_valid = 1'b0; bus.cfg_gain = '0; bus.cfg_off = '0; bus.cfg_bypass = 1'b0;
    bus.fade_cmd = 2'b00; bus.hs_in = 1'b0; bus.vs_in = 1'b0; bus.de_in = 1'b0;
    bus.data_in = '0;
    tick();
    tick();
    chk("rst_data",  {8'b0, bus.data_out}, 32'h0);
    chk("rst_syncs", {29'b0, bus.hs_out, bus.vs_out, bus.de_out}, 32'h0);
    chk("rst_ready", {31'b0, bus.cfg_ready}, 32'h1);
    chk("rst_busy",  {31'b0, bus.fade_busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    pixel("unity", 24'h123456, 1'b1, 24'h123456);
    frame();
    tick();
    chk("vs_early", {31'b0, bus.vs_out}, 32'h0);
    tick();
    chk("vs_align", {31'b0, bus.vs_out}, 32'h1);

    // R gain 2.0 off +100, G off -50: accepted mid-frame, a second offer is ignored
    cfg(9'd256, 9'd128, 9'd128, 9'd100, 9'h1CE, 9'd0, 1'b0);
    chk("ready_pend", {31'b0, bus.cfg_ready}, 32'h0);
    cfg(9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 1'b1);
    chk("ready_pend2", {31'b0, bus.cfg_ready}, 32'h0);
    pixel("old_until_fs", 24'hC81E40, 1'b1, 24'hC81E40);
    bus.vs_in = 1'b1;
    tick();
    chk("ready_back", {31'b0, bus.cfg_ready}, 32'h1);
    bus.vs_in = 1'b0;
    tick();
    pixel("clamp", 24'hC81E40, 1'b1, 24'hFF0040);

    // offer in the same cycle as frame start: takes effect one frame later
    bus.cfg_gain = {9'd192, 9'd64, 9'd0};
    bus.cfg_off = '0;
    bus.cfg_bypass = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.vs_in = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.vs_in = 1'b0;
    tick();
    chk("ready_same_fs", {31'b0, bus.cfg_ready}, 32'h0);
    pixel("same_fs_old", 24'h0303FF, 1'b1, 24'h6A00FF);
    frame();
    pixel("round", 24'h0303FF, 1'b1, 24'h050200);

    cfg(9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 1'b1);
    frame();
    pixel("bypass", 24'hABCDEF, 1'b1, 24'hABCDEF);
    pixel("de_low", 24'hABCDEF, 1'b0, 24'h000000);

    cfg(9'd128, 9'd128, 9'd128, 9'd0, 9'd0, 9'd0, 1'b0);
    frame();
    pixel("unity2", 24'hC8C8C8, 1'b1, 24'hC8C8C8);

    fade(2'b10);
    chk("busy_out", {31'b0, bus.fade_busy}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      frame();
      pixel($sformatf("fadeout%0d", i), 24'hC8C8C8, 1'b1, {3{fo_exp[i]}});
      chk($sformatf("busy_out%0d", i), {31'b0, bus.fade_busy}, (i < 3) ? 32'h1 : 32'h0);
    end

    fade(2'b01);
    for (int i = 0; i < 2; i++) begin
      frame();
      pixel($sformatf("fadein_a%0d", i), 24'hC8C8C8, 1'b1, {3{fi_exp[i]}});
    end
    fade(2'b10);
    frame();
    pixel("reverse", 24'hC8C8C8, 1'b1, 24'h000000);
    chk("busy_rev", {31'b0, bus.fade_busy}, 32'h0);

    fade(2'b01);
    for (int i = 0; i < 5; i++) begin
      frame();
      pixel($sformatf("fadein_b%0d", i), 24'hC8C8C8, 1'b1, {3{fi_exp[i]}});
      chk($sformatf("busy_in%0d", i), {31'b0, bus.fade_busy}, (i < 4) ? 32'h1 : 32'h0);
    end

    cfg(9'd256, 9'd128, 9'd128, 9'd100, 9'h1CE, 9'd0, 1'b0);
    frame();
    cfg(9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 1'b0);
    bus.data_in = 24'hC81E40;
    bus.de_in = 1'b1;
    bus.hs_in = 1'b1;
    repeat (4) tick();
    chk("pre_reset", {6'b0, bus.de_out, bus.hs_out, bus.data_out}, {8'h03, 24'hFF0040});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", {6'b0, bus.de_out, bus.hs_out, bus.data_out}, 32'h0);
    chk("async_rst_ready", {31'b0, bus.cfg_ready}, 32'h1);
    bus.data_in = '0;
    bus.de_in = 1'b0;
    bus.hs_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pixel("post_rst_unity", 24'hC81E40, 1'b1, 24'hC81E40);
    frame();
    pixel("pending_dropped", 24'hC81E40, 1'b1, 24'hC81E40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
